// File: rtl/stepper_pkg.sv
// stepper_pkg: mode encodings, half-step coil table and phase decode shared by the stepper sequencer
package stepper_pkg;
    localparam int PHASE_W = 3;
    localparam logic [1:0] MODE_WAVE  = 2'b00;
    localparam logic [1:0] MODE_FULL  = 2'b01;
    localparam logic [1:0] MODE_HALF  = 2'b10;
    localparam logic [1:0] MODE_COAST = 2'b11;
    // entry [0] is the lowest nibble: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001
    localparam logic [7:0][3:0] HALF_TABLE = {4'b1001, 4'b1000, 4'b1100, 4'b0100,
                                              4'b0110, 4'b0010, 4'b0011, 4'b0001};

    function automatic logic [3:0] coil_decode(input logic [1:0] mode, input logic [PHASE_W-1:0] p);
        return mode == MODE_WAVE ? HALF_TABLE[p & 3'd6] :
               mode == MODE_FULL ? HALF_TABLE[p | 3'd1] :
               mode == MODE_HALF ? HALF_TABLE[p] : 4'b0000;
    endfunction
endpackage

// File: rtl/step_rate_gen.sv
// step_rate_gen: programmable divider issuing a registered one-cycle tick every rate_div+1 cycles
module step_rate_gen #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    input  logic                 clear,
    input  logic [DIV_WIDTH-1:0] rate_div,
    output logic                 tick
);
    logic [DIV_WIDTH-1:0] cnt;
    logic                 active;
    logic                 term;

    assign active = run && !clear && rate_div != '0;
    // >= so a rate_div lowered below the running count terminates on the next edge
    assign term   = cnt >= rate_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= active && term;
            cnt  <= (active && !term) ? cnt + DIV_WIDTH'(1) : '0;
        end
    end
endmodule

// File: rtl/stepper_sequencer.sv
// stepper_sequencer: wave/full/half-step coil sequencer with signed position, fed by
// synchronised STEP/DIR pins or the internal rate generator
module stepper_sequencer
    import stepper_pkg::*;
#(
    parameter int POS_WIDTH = 32,
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 ext_ctrl,
    input  logic                 step_in,
    input  logic                 dir_in,
    input  logic                 run,
    input  logic                 dir_int,
    input  logic [DIV_WIDTH-1:0] rate_div,
    input  logic [1:0]           mode,
    input  logic                 pos_clr,
    output logic [3:0]           coils_out,
    output logic [POS_WIDTH-1:0] position,
    output logic                 step_pulse
);
    logic                 step_s1, step_s2, step_prev, edge_q;
    logic                 dir_s1, dir_s2;
    logic                 tick, step, fwd;
    logic [PHASE_W-1:0]   phase, phase_nxt, inc;
    logic [POS_WIDTH-1:0] pos_nxt;

    step_rate_gen #(.DIV_WIDTH(DIV_WIDTH)) u_rate (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .clear    (!ena || ext_ctrl),
        .rate_div (rate_div),
        .tick     (tick)
    );

    // step_prev always tracks the synchronised level, so edges seen while the
    // internal source is selected are absorbed and a source switch cannot fake a step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            step_prev <= 1'b0;
            edge_q    <= 1'b0;
            dir_s1    <= 1'b0;
            dir_s2    <= 1'b0;
        end else begin
            step_s1   <= step_in;
            step_s2   <= step_s1;
            step_prev <= step_s2;
            edge_q    <= ext_ctrl && step_s2 && !step_prev;
            dir_s1    <= dir_in;
            dir_s2    <= dir_s1;
        end
    end

    always_comb begin
        step      = ena && (ext_ctrl ? edge_q : tick);
        fwd       = ext_ctrl ? dir_s2 : dir_int;
        inc       = mode == MODE_HALF ? 3'd1 : 3'd2;
        phase_nxt = !step ? phase : fwd ? phase + inc : phase - inc;
        pos_nxt   = pos_clr ? '0 : !step ? position :
                    fwd ? position + POS_WIDTH'(1) : position - POS_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase      <= '0;
            position   <= '0;
            step_pulse <= 1'b0;
            coils_out  <= 4'b0000;
        end else begin
            phase      <= phase_nxt;
            position   <= pos_nxt;
            step_pulse <= step;
            coils_out  <= ena ? coil_decode(mode, phase_nxt) : 4'b0000;
        end
    end
endmodule

// File: tb/tb_stepper_sequencer.sv
// tb_stepper_sequencer: directed vector table plus hand-written multi-cycle sequences
module tb_stepper_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, ena, ext_ctrl, step_in, dir_in, run, dir_int, pos_clr;
    logic [15:0] rate_div;
    logic [1:0]  mode;
    logic [3:0]  coils_out;
    logic [31:0] position;
    logic        step_pulse;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    stepper_sequencer #(.POS_WIDTH(32), .DIV_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .ext_ctrl   (ext_ctrl),
        .step_in    (step_in),
        .dir_in     (dir_in),
        .run        (run),
        .dir_int    (dir_int),
        .rate_div   (rate_div),
        .mode       (mode),
        .pos_clr    (pos_clr),
        .coils_out  (coils_out),
        .position   (position),
        .step_pulse (step_pulse)
    );

    typedef struct {
        bit          step;
        bit          clr;
        logic [1:0]  mode;
        bit          dir;
        logic [3:0]  coils;
        logic [31:0] pos;
    } vec_t;

    vec_t vecs [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ext_pulse(input int idx, input logic [3:0] ec, input logic [31:0] ep);
        step_in = 1'b1;
        repeat (3) @(negedge clk);
        chk($sformatf("vec%0d_latency", idx), 32'(step_pulse), 32'd0);
        @(negedge clk);
        chk($sformatf("vec%0d_pulse", idx), 32'(step_pulse), 32'd1);
        chk($sformatf("vec%0d_coils", idx), 32'(coils_out), 32'(ec));
        chk($sformatf("vec%0d_pos", idx), position, ep);
        step_in = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d_width", idx), 32'(step_pulse), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_pulse(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!step_pulse && cyc < 40);
    endtask

    task automatic count_pulses(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (step_pulse) c++;
        end
    endtask

    initial begin
        int cyc, c;
        logic [3:0] int_coils [7];
        int_coils = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
        vecs[0]  = '{0, 0, 2'b01, 1, 4'b0011, 32'd0};
        vecs[1]  = '{1, 0, 2'b01, 1, 4'b0110, 32'd1};
        vecs[2]  = '{1, 0, 2'b01, 1, 4'b1100, 32'd2};
        vecs[3]  = '{1, 0, 2'b01, 1, 4'b1001, 32'd3};
        vecs[4]  = '{1, 0, 2'b01, 1, 4'b0011, 32'd4};
        vecs[5]  = '{1, 0, 2'b01, 1, 4'b0110, 32'd5};
        vecs[6]  = '{1, 0, 2'b01, 1, 4'b1100, 32'd6};
        vecs[7]  = '{1, 0, 2'b01, 1, 4'b1001, 32'd7};
        vecs[8]  = '{1, 0, 2'b01, 1, 4'b0011, 32'd8};
        vecs[9]  = '{0, 1, 2'b10, 1, 4'b0001, 32'd0};
        vecs[10] = '{1, 0, 2'b10, 0, 4'b1001, 32'hFFFF_FFFF};
        vecs[11] = '{1, 0, 2'b10, 0, 4'b1000, 32'hFFFF_FFFE};
        vecs[12] = '{1, 0, 2'b10, 0, 4'b1100, 32'hFFFF_FFFD};
        vecs[13] = '{0, 0, 2'b00, 0, 4'b0100, 32'hFFFF_FFFD};
        vecs[14] = '{0, 0, 2'b01, 0, 4'b1100, 32'hFFFF_FFFD};
        vecs[15] = '{0, 0, 2'b11, 0, 4'b0000, 32'hFFFF_FFFD};
        vecs[16] = '{1, 0, 2'b11, 1, 4'b0000, 32'hFFFF_FFFE};
        vecs[17] = '{0, 0, 2'b10, 1, 4'b1001, 32'hFFFF_FFFE};

        rst_n = 1'b0; ena = 1'b0; ext_ctrl = 1'b1; step_in = 1'b0; dir_in = 1'b1;
        run = 1'b0; dir_int = 1'b1; rate_div = 16'd0; mode = 2'b01; pos_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_coils", 32'(coils_out), 32'd0);
        chk("rst_pos", position, 32'd0);
        chk("rst_pulse", 32'(step_pulse), 32'd0);
        rst_n = 1'b1;
        ena = 1'b1;

        for (int i = 0; i < 18; i++) begin
            mode   = vecs[i].mode;
            dir_in = vecs[i].dir;
            if (vecs[i].step) begin
                ext_pulse(i, vecs[i].coils, vecs[i].pos);
            end else begin
                pos_clr = vecs[i].clr;
                @(negedge clk);
                pos_clr = 1'b0;
                chk($sformatf("vec%0d_pulse", i), 32'(step_pulse), 32'd0);
                chk($sformatf("vec%0d_coils", i), 32'(coils_out), 32'(vecs[i].coils));
                chk($sformatf("vec%0d_pos", i), position, vecs[i].pos);
            end
        end

        // internal generator, wave mode, phase starts at 7
        ext_ctrl = 1'b0; mode = 2'b00; dir_int = 1'b1; rate_div = 16'd9; pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        chk("int_start_coils", 32'(coils_out), 32'b1000);
        chk("int_start_pos", position, 32'd0);
        run = 1'b1;
        for (int k = 0; k < 7; k++) begin
            wait_pulse(cyc);
            chk($sformatf("int%0d_period", k), 32'(cyc), k == 0 ? 32'd11 : 32'd10);
            chk($sformatf("int%0d_coils", k), 32'(coils_out), 32'(int_coils[k]));
            chk($sformatf("int%0d_pos", k), position, 32'(k + 1));
        end

        repeat (9) @(negedge clk);
        chk("clr_pre_pulse", 32'(step_pulse), 32'd0);
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        chk("clr_pulse", 32'(step_pulse), 32'd1);
        chk("clr_pos", position, 32'd0);
        chk("clr_coils", 32'(coils_out), 32'b1000);

        mode = 2'b11;
        @(negedge clk);
        chk("coast_coils", 32'(coils_out), 32'd0);
        wait_pulse(cyc);
        chk("coast_pulse", 32'(step_pulse), 32'd1);
        chk("coast_step_coils", 32'(coils_out), 32'd0);
        chk("coast_pos", position, 32'd1);

        rate_div = 16'd0;
        count_pulses(30, c);
        chk("div0_pulses", 32'(c), 32'd0);
        chk("div0_pos", position, 32'd1);

        mode = 2'b00; rate_div = 16'd9;
        wait_pulse(cyc);
        chk("resume_period", 32'(cyc), 32'd11);
        chk("resume_coils", 32'(coils_out), 32'b0010);
        chk("resume_pos", position, 32'd2);
        repeat (4) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        chk("ena0_coils", 32'(coils_out), 32'd0);
        count_pulses(30, c);
        chk("ena0_pulses", 32'(c), 32'd0);
        chk("ena0_pos", position, 32'd2);

        ena = 1'b1; run = 1'b0;
        step_in = 1'b1;
        repeat (4) @(negedge clk);
        ext_ctrl = 1'b1;
        count_pulses(6, c);
        chk("switch_pulses", 32'(c), 32'd0);
        chk("switch_pos", position, 32'd2);
        chk("switch_coils", 32'(coils_out), 32'b0010);
        step_in = 1'b0;
        repeat (3) @(negedge clk);

        step_in = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_coils", 32'(coils_out), 32'd0);
        chk("async_pos", position, 32'd0);
        chk("async_pulse", 32'(step_pulse), 32'd0);
        step_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_coils", 32'(coils_out), 32'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stepper_sequencer.md
# stepper_sequencer

Parametrised unipolar/bipolar stepper phase sequencer with selectable wave, full-step and half-step drive, bidirectional stepping and a signed position counter. Steps come either from an external STEP/DIR pin pair, synchronised and edge-detected, or from an internal programmable step-rate generator. It sits between the top-level pin wrapper and the coil driver outputs, replacing the fixed full-step-only forward counter.

## Interface
- POS_WIDTH, 32, width of two's-complement position counter
- DIV_WIDTH, 16, width of internal rate divider
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  design enable; 0 = coils off, steps ignored
- ext_ctrl  in  1  1 = external step_in/dir_in source, 0 = internal generator
- step_in  in  1  external step pin, asynchronous, rising edge = one step
- dir_in  in  1  external direction pin, asynchronous
- run  in  1  internal generator enable
- dir_int  in  1  internal-mode direction (1 = forward)
- rate_div  in  DIV_WIDTH  internal step period minus 1; 0 = generator stopped
- mode  in  2  00 wave, 01 full, 10 half, 11 coast (all coils off)
- pos_clr  in  1  synchronous position clear
- coils_out  out  4  coil drive {D,C,B,A}, registered
- position  out  POS_WIDTH  signed step count, registered
- step_pulse  out  1  one-cycle pulse per accepted step, registered

## Operation
- Reset: coils_out=0, position=0, step_pulse=0, phase=0, rate counter=0, synchroniser flops=0.
- 3-bit phase index p; half-step table: 0:0001 1:0011 2:0010 3:0110 4:0100 5:1100 6:1000 7:1001.
- Output decode: wave = table[p & 6], full = table[p | 1], half = table[p], coast = 0000; decode is evaluated on the registered phase, so a mode change takes effect without a step.
- Step increment: wave/full move p by ±2; half moves p by ±1. Arithmetic is mod 8. Forward = +, reverse = −.
- Direction: dir_in (2-FF synchronised) when ext_ctrl=1, dir_int otherwise; sampled on the step cycle.
- position: +1 forward, −1 reverse per accepted step in every non-coast mode, with modulo 2^POS_WIDTH wrap (0 − 1 = all-ones).
- coast mode: steps are still accepted (position and p update) but coils stay 0000.
- ena=0: coils_out=0, no steps accepted, rate counter held at 0, position/p held.
- pos_clr=1: position←0 and overrides a simultaneous step on position; p still advances.
- External source: step_in is 2-FF synchronised; a rising edge on the synchronised signal is one step. Edges while ext_ctrl=0 are discarded.
- Internal source: counter counts 0..rate_div while run=1 and rate_div≠0; at terminal count it issues a step and returns to 0. run=0 or rate_div=0 holds the counter at 0.
- Source switch (ext_ctrl toggles): rate counter clears to 0; the edge detector's previous-value flop reloads from the current synchronised level, so no spurious step occurs.
- rate_div written mid-count: if the counter is already ≥ the new value, the next cycle is treated as terminal.

## Timing
- External: step_in rising before clk edge N → coils_out/position/step_pulse update at edge N+3 (2 sync + 1 output register).
- Internal: step period = rate_div+1 cycles. The first step is issued rate_div+1 cycles after run rises; outputs update on that terminal edge +1.
- step_pulse is high for exactly one cycle, coincident with the new coils_out/position.
- Minimum external step spacing: step_in must be high ≥2 cycles and low ≥2 cycles. Faster input is not guaranteed.
- Mode change → coils_out updates on the next edge.

## Structure
- Package stepper_pkg: mode encoding constants (MODE_WAVE, MODE_FULL, MODE_HALF, MODE_COAST), 8-entry half-step table constant, phase index width.
- Sub-module step_rate_gen (DIV_WIDTH counter, run/rate_div/clear in, tick out). Synchroniser, edge detect, phase/position registers and decode stay in the top.

## Test plan
- Reset, ena=1, mode=full, ext_ctrl=1, dir_in=1, 4 step_in pulses → coils 0011,0110,1100,1001 back to 0011 after 4 more; position=4; each update 3 cycles after the edge.
- mode=half, dir_in=0, 3 pulses from p=0 → coils 1001,1000,1100; position=−3 (0xFFFFFFFD).
- Internal: ext_ctrl=0, run=1, rate_div=9, mode=wave → step_pulse every 10 cycles; 0001→0010→0100→1000; rate_div=0 → no pulses.
- pos_clr coincident with a step at position=7 → position=0, coils advance, step_pulse=1; mode=coast → coils 0000, position keeps counting.
- ena=0 mid-run → coils 0000 next edge, position frozen; toggling ext_ctrl while step_in is held high → no step.
- Assert rst_n low asynchronously mid-step → all outputs 0 immediately, with no clock required.
